// File: rtl/config_pkg.sv
// Shared types and sizing helpers for the configuration chain loader and the
// chain tiles that consume its bitstream.
package config_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFETCH,
    ST_SHIFT,
    ST_LATCH,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int CONFIG_WIDTH      = 650;
  localparam int CONFIG_WORD_WIDTH = 32;

  function automatic int calc_nwords(input int chain_length, input int word_width);
    return (chain_length + word_width - 1) / word_width;
  endfunction

  // Bits carried by the final word, left-aligned; its low bits are padding.
  function automatic int calc_rem(input int chain_length, input int word_width);
    return chain_length - (calc_nwords(chain_length, word_width) - 1) * word_width;
  endfunction

endpackage

// File: rtl/config_word_buf.sv
// One-entry prefetch register between the word stream and the shift register,
// with a same-cycle bypass so a word arriving exactly when needed is usable.
module config_word_buf #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_xfer,
  input  logic             i_take,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_avail,
  output logic             o_vld_nxt,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_nxt;
  logic             r_nxt_vld;

  assign o_avail = r_nxt_vld | i_xfer;
  assign o_data  = r_nxt_vld ? r_nxt : i_data;

  always_comb begin
    o_vld_nxt = r_nxt_vld;
    if (i_clr) begin
      o_vld_nxt = 1'b0;
    end else if (i_take) begin
      // A word arriving while the stored one is consumed replaces it.
      o_vld_nxt = r_nxt_vld & i_xfer;
    end else begin
      o_vld_nxt = r_nxt_vld | i_xfer;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_nxt     <= '0;
      r_nxt_vld <= 1'b0;
    end else begin
      r_nxt_vld <= o_vld_nxt;
      if (i_xfer && (r_nxt_vld || !i_take)) begin
        r_nxt <= i_data;
      end
    end
  end

endmodule

// File: rtl/config_loader.sv
// Configuration chain loader: accepts bitstream words and shifts them MSB-first
// onto the daisy chain in one gap-free enable window, then commits on its fall.
module config_loader
  import config_pkg::*;
#(
  parameter int CHAIN_LENGTH = CONFIG_WIDTH,
  parameter int WORD_WIDTH   = CONFIG_WORD_WIDTH
) (
  input  logic                  config_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_in,
  output logic                  config_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int NWORDS = calc_nwords(CHAIN_LENGTH, WORD_WIDTH);
  localparam int CNT_W  = $clog2(CHAIN_LENGTH + 1);
  localparam int WB_W   = $clog2(WORD_WIDTH);
  localparam int WC_W   = $clog2(NWORDS + 1);

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CHAIN_LENGTH);
  localparam logic [WC_W-1:0]  WORDS_MAX = WC_W'(NWORDS);
  localparam logic [WB_W-1:0]  WORD_LAST = WB_W'(WORD_WIDTH - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [WORD_WIDTH-1:0] r_shreg;
  logic [WB_W-1:0]       r_word_bit;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [WC_W-1:0]       r_words_acc;

  logic r_word_ready;
  logic r_config_in;
  logic r_config_en;
  logic r_busy;
  logic r_done;
  logic r_error;

  logic                  w_clr;
  logic                  w_xfer;
  logic                  w_word_empty;
  logic                  w_last_bit;
  logic                  w_load;
  logic                  w_shift;
  logic                  w_buf_avail;
  logic                  w_buf_vld_nxt;
  logic [WORD_WIDTH-1:0] w_buf_data;
  logic [WC_W-1:0]       w_words_acc_nxt;

  logic w_word_ready_nxt;
  logic w_config_in_nxt;
  logic w_config_en_nxt;
  logic w_busy_nxt;
  logic w_done_nxt;
  logic w_error_nxt;

  assign w_clr        = (r_state == ST_IDLE) && start;
  assign w_xfer       = word_valid && r_word_ready;
  assign w_word_empty = (r_word_bit == '0);
  assign w_last_bit   = (r_bit_cnt == LAST_CNT);

  // A load refills the shift register from the prefetch slot (or the bypass).
  assign w_load  = ((r_state == ST_PREFETCH) && w_xfer) ||
                   ((r_state == ST_SHIFT) && !w_last_bit && w_word_empty && w_buf_avail);
  assign w_shift = (r_state == ST_SHIFT) && !w_last_bit && !w_word_empty;

  assign w_words_acc_nxt = w_clr ? '0 : (r_words_acc + WC_W'(w_xfer));

  config_word_buf #(
    .WIDTH (WORD_WIDTH)
  ) u_word_buf (
    .i_clk     (config_clk),
    .i_rst     (rst),
    .i_clr     (w_clr),
    .i_xfer    (w_xfer),
    .i_take    (w_load),
    .i_data    (word_data),
    .o_avail   (w_buf_avail),
    .o_vld_nxt (w_buf_vld_nxt),
    .o_data    (w_buf_data)
  );

  always_ff @(posedge config_clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_PREFETCH;
      end
      ST_PREFETCH: begin
        if (w_xfer) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_last_bit) begin
          w_state_nxt = ST_LATCH;
        end else if (w_word_empty && !w_buf_avail) begin
          w_state_nxt = ST_ERROR;
        end
      end
      ST_LATCH: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      ST_ERROR: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so each register shows the
  // value belonging to the cycle it is entering.
  always_comb begin
    w_config_in_nxt = 1'b0;
    if (w_load) begin
      w_config_in_nxt = w_buf_data[WORD_WIDTH-1];
    end else if (w_shift) begin
      w_config_in_nxt = r_shreg[WORD_WIDTH-1];
    end
    w_config_en_nxt  = (w_state_nxt == ST_SHIFT);
    w_busy_nxt       = (w_state_nxt != ST_IDLE);
    w_done_nxt       = (w_state_nxt == ST_DONE);
    w_error_nxt      = (w_state_nxt == ST_ERROR);
    w_word_ready_nxt = (w_state_nxt == ST_PREFETCH) ||
                       ((w_state_nxt == ST_SHIFT) && !w_buf_vld_nxt &&
                        (w_words_acc_nxt < WORDS_MAX));
  end

  always_ff @(posedge config_clk or posedge rst) begin
    if (rst) begin
      r_word_ready <= 1'b0;
      r_config_in  <= 1'b0;
      r_config_en  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_word_ready <= w_word_ready_nxt;
      r_config_in  <= w_config_in_nxt;
      r_config_en  <= w_config_en_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_error      <= w_error_nxt;
    end
  end

  always_ff @(posedge config_clk or posedge rst) begin
    if (rst) begin
      r_shreg     <= '0;
      r_word_bit  <= '0;
      r_bit_cnt   <= '0;
      r_words_acc <= '0;
    end else begin
      r_words_acc <= w_words_acc_nxt;
      if (w_clr) begin
        r_shreg    <= '0;
        r_word_bit <= '0;
        r_bit_cnt  <= '0;
      end else if (w_load) begin
        r_shreg    <= w_buf_data << 1;
        r_word_bit <= WORD_LAST;
        r_bit_cnt  <= r_bit_cnt + 1'b1;
      end else if (w_shift) begin
        r_shreg    <= r_shreg << 1;
        r_word_bit <= r_word_bit - 1'b1;
        r_bit_cnt  <= r_bit_cnt + 1'b1;
      end
    end
  end

  assign word_ready = r_word_ready;
  assign config_in  = r_config_in;
  assign config_en  = r_config_en;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: table-driven and randomized loads on a 40/16
// instance checked against a chain model, plus a 64/32 instance.
`timescale 1ns/1ps
module tb_config_loader;

  localparam int CL_A = 40;
  localparam int WW_A = 16;
  localparam int CL_B = 64;
  localparam int WW_B = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            start_a = 1'b0;
  logic [WW_A-1:0] data_a  = '0;
  logic            valid_a = 1'b0;
  logic            ready_a, cin_a, en_a, busy_a, done_a, err_a;

  logic            start_b = 1'b0;
  logic [WW_B-1:0] data_b  = '0;
  logic            valid_b = 1'b0;
  logic            ready_b, cin_b, en_b, busy_b, done_b, err_b;

  config_loader #(.CHAIN_LENGTH(CL_A), .WORD_WIDTH(WW_A)) u_a (
    .config_clk(clk), .rst(rst), .start(start_a), .word_data(data_a),
    .word_valid(valid_a), .word_ready(ready_a), .config_in(cin_a),
    .config_en(en_a), .busy(busy_a), .done(done_a), .error(err_a));

  config_loader #(.CHAIN_LENGTH(CL_B), .WORD_WIDTH(WW_B)) u_b (
    .config_clk(clk), .rst(rst), .start(start_b), .word_data(data_b),
    .word_valid(valid_b), .word_ready(ready_b), .config_in(cin_b),
    .config_en(en_b), .busy(busy_b), .done(done_b), .error(err_b));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Chain models: shift while enabled, commit on the enable falling edge.
  logic [CL_A-1:0] chain_a = '0, latch_a = '0;
  int en_cnt_a, burst_a, rise_a, done_cnt_a, err_cnt_a, done_cyc_a, err_cyc_a, busy_cnt_a;
  logic en_prev_a = 1'b0;

  always @(negedge clk) begin
    if (!en_a && en_prev_a) latch_a = chain_a;
    if (en_a) begin
      if (!en_prev_a) begin burst_a++; rise_a = cyc; end
      chain_a = {chain_a[CL_A-2:0], cin_a};
      en_cnt_a++;
    end
    en_prev_a = en_a;
    if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
    if (err_a)  begin err_cnt_a++;  err_cyc_a  = cyc; end
    if (busy_a) busy_cnt_a++;
  end

  logic [CL_B-1:0] chain_b = '0, latch_b = '0;
  int en_cnt_b, burst_b, rise_b, done_cnt_b, err_cnt_b, done_cyc_b;
  logic en_prev_b = 1'b0;

  always @(negedge clk) begin
    if (!en_b && en_prev_b) latch_b = chain_b;
    if (en_b) begin
      if (!en_prev_b) begin burst_b++; rise_b = cyc; end
      chain_b = {chain_b[CL_B-2:0], cin_b};
      en_cnt_b++;
    end
    en_prev_b = en_b;
    if (done_b) begin done_cnt_b++; done_cyc_b = cyc; end
    if (err_b)  err_cnt_b++;
  end

  task automatic clr_mon();
    en_cnt_a = 0; burst_a = 0; rise_a = -1; done_cnt_a = 0; err_cnt_a = 0;
    done_cyc_a = -1; err_cyc_a = -1; busy_cnt_a = 0;
    en_cnt_b = 0; burst_b = 0; rise_b = -1; done_cnt_b = 0; err_cnt_b = 0;
    done_cyc_b = -1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // g2/g3: earliest shift-cycle index at which words 2 and 3 are offered.
  typedef struct {
    logic [2:0][WW_A-1:0] w;
    int   pre_dly;
    int   g2;
    int   g3;
    bit   extra;
    int   exp_en;
    int   exp_acc;
    bit   exp_done;
    logic [CL_A-1:0] exp_latch;
  } vec_t;

  vec_t tab[16];

  function automatic vec_t mk(input logic [WW_A-1:0] w0, input logic [WW_A-1:0] w1,
                              input logic [WW_A-1:0] w2, input int pre, input int g2,
                              input int g3, input bit extra, input int en, input int acc,
                              input bit dn, input logic [CL_A-1:0] lat);
    vec_t v;
    v.w = {w2, w1, w0};
    v.pre_dly = pre; v.g2 = g2; v.g3 = g3; v.extra = extra;
    v.exp_en = en; v.exp_acc = acc; v.exp_done = dn; v.exp_latch = lat;
    return v;
  endfunction

  // Each word after the first must arrive by the cycle the last bit of the
  // previous word is shifted; word 3 also waits for the prefetch slot to free
  // up when word 1 runs out at shift cycle 16.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int t3;
    logic [3*WW_A-1:0] cat;
    r = v;
    t3 = v.g3;
    if (t3 < v.g2 + 1) t3 = v.g2 + 1;
    if (t3 < WW_A) t3 = WW_A;
    if (v.g2 > WW_A - 1) begin
      r.exp_en = WW_A; r.exp_acc = 1; r.exp_done = 1'b0;
    end else if (t3 > 2 * WW_A - 1) begin
      r.exp_en = 2 * WW_A; r.exp_acc = 2; r.exp_done = 1'b0;
    end else begin
      r.exp_en = CL_A; r.exp_acc = 3; r.exp_done = 1'b1;
    end
    cat = {v.w[0], v.w[1], v.w[2]};
    r.exp_latch = cat[3*WW_A-1 -: CL_A];
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int ot[4];
    int widx, c0, s0, t_end;
    bit hs;
    ot[0] = -1; ot[1] = v.g2; ot[2] = v.g3; ot[3] = 0;
    clr_mon();
    @(posedge clk); #1;
    c0 = cyc;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    s0 = c0 + 2 + v.pre_dly;
    widx = 0;
    for (int k = -1 - v.pre_dly; k < 46; k++) begin
      start_a = v.extra && (k == 10);
      valid_a = (widx < (v.extra ? 4 : 3)) && (k >= ot[widx & 3]);
      data_a  = (widx < 3) ? v.w[widx] : 16'hFFFF;
      @(negedge clk);
      hs = valid_a && ready_a;
      @(posedge clk); #1;
      if (hs) widx++;
    end
    valid_a = 1'b0;
    start_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    t_end = v.exp_done ? (s0 + CL_A + 1) : (s0 + v.exp_en);
    chk({tag, "/en_cycles"}, 64'(en_cnt_a), 64'(v.exp_en));
    chk({tag, "/en_bursts"}, 64'(burst_a), 64'd1);
    chk({tag, "/en_rise_cycle"}, 64'(rise_a), 64'(s0));
    chk({tag, "/done_pulses"}, 64'(done_cnt_a), 64'(v.exp_done));
    chk({tag, "/error_pulses"}, 64'(err_cnt_a), 64'(!v.exp_done));
    chk({tag, "/words_accepted"}, 64'(widx), 64'(v.exp_acc));
    chk({tag, "/busy_cycles"}, 64'(busy_cnt_a), 64'(t_end - c0));
    chk({tag, "/busy_end"}, 64'(busy_a), 64'd0);
    if (v.exp_done) begin
      chk({tag, "/done_cycle"}, 64'(done_cyc_a), 64'(t_end));
      chk({tag, "/latched"}, 64'(latch_a), 64'(v.exp_latch));
    end else begin
      chk({tag, "/error_cycle"}, 64'(err_cyc_a), 64'(t_end));
    end
  endtask

  initial begin
    logic [WW_B-1:0] wb0, wb1;
    int widx, c0, hs_cnt;
    bit hs, pre_en;
    vec_t v;

    tab[0] = mk(16'hA5C3, 16'h0FF0, 16'h81FF, 0,  0,  0, 1'b0, 40, 3, 1'b1, 40'hA5C30FF081);
    tab[1] = mk(16'hA5C3, 16'h0FF0, 16'h81FF, 0,  0, 40, 1'b0, 32, 2, 1'b0, 40'hA5C30FF081);
    tab[2] = mk(16'hA5C3, 16'h0FF0, 16'h81FF, 20, 0,  0, 1'b0, 40, 3, 1'b1, 40'hA5C30FF081);
    tab[3] = mk(16'hA5C3, 16'h0FF0, 16'h81FF, 0,  0,  0, 1'b1, 40, 3, 1'b1, 40'hA5C30FF081);
    tab[4] = mk(16'h1234, 16'h5678, 16'h9ABC, 0, 16,  0, 1'b0, 16, 1, 1'b0, 40'h123456789A);
    tab[5] = mk(16'h1234, 16'h5678, 16'h9ABC, 1,  3, 31, 1'b0, 40, 3, 1'b1, 40'h123456789A);
    tab[6] = mk(16'h1234, 16'h5678, 16'h9ABC, 1,  3, 32, 1'b0, 32, 2, 1'b0, 40'h123456789A);
    tab[7] = mk(16'hFFFF, 16'h0001, 16'h8000, 2, 15,  0, 1'b0, 40, 3, 1'b1, 40'hFFFF000180);
    for (int i = 8; i < 16; i++) begin
      v = mk(16'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 4)),
             int'($urandom_range(0, 18)), int'($urandom_range(0, 36)),
             1'($urandom_range(0, 1)), 0, 0, 1'b0, '0);
      tab[i] = model(v);
    end

    clr_mon();
    #3;
    chk("reset_outputs_a", {58'd0, ready_a, cin_a, en_a, busy_a, done_a, err_a}, 64'd0);
    chk("reset_outputs_b", {58'd0, ready_b, cin_b, en_b, busy_b, done_b, err_b}, 64'd0);
    repeat (2) @(posedge clk);
    #4 rst = 1'b0;

    // Words offered while idle must not be taken.
    @(posedge clk); #1;
    valid_a = 1'b1; data_a = 16'hDEAD;
    hs_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (valid_a && ready_a) hs_cnt++;
      @(posedge clk); #1;
    end
    valid_a = 1'b0;
    chk("idle_no_accept", 64'(hs_cnt), 64'd0);
    chk("idle_not_busy", 64'(busy_a), 64'd0);

    for (int i = 0; i < 16; i++) run_vec(tab[i], $sformatf("vec%0d", i));

    // Reset while bit 17 is on the chain, then a clean reload.
    clr_mon();
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    widx = 0;
    for (int k = -1; k < 17; k++) begin
      valid_a = (widx < 3);
      data_a  = tab[0].w[widx % 3];
      @(negedge clk);
      hs = valid_a && ready_a;
      @(posedge clk); #1;
      if (hs) widx++;
    end
    pre_en = en_a;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_en_before", 64'(pre_en), 64'd1);
    chk("rst_mid_outputs", {58'd0, ready_a, cin_a, en_a, busy_a, done_a, err_a}, 64'd0);
    valid_a = 1'b0;
    #2 rst = 1'b0;
    run_vec(tab[0], "reload");

    // 64-bit chain, two full 32-bit words.
    wb0 = $urandom;
    wb1 = $urandom;
    clr_mon();
    @(posedge clk); #1;
    c0 = cyc;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    widx = 0;
    for (int k = -1; k < 70; k++) begin
      valid_b = (widx < 2);
      data_b  = (widx == 0) ? wb0 : wb1;
      @(negedge clk);
      hs = valid_b && ready_b;
      @(posedge clk); #1;
      if (hs) widx++;
    end
    valid_b = 1'b0;
    chk("b/en_cycles", 64'(en_cnt_b), 64'(CL_B));
    chk("b/en_bursts", 64'(burst_b), 64'd1);
    chk("b/en_rise_cycle", 64'(rise_b), 64'(c0 + 2));
    chk("b/done_pulses", 64'(done_cnt_b), 64'd1);
    chk("b/error_pulses", 64'(err_cnt_b), 64'd0);
    chk("b/done_cycle", 64'(done_cyc_b), 64'(c0 + 2 + CL_B + 1));
    chk("b/words_accepted", 64'(widx), 64'd2);
    chk("b/latched", latch_b, {wb0, wb1});
    chk("b/busy_end", 64'(busy_b), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
